// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store access controller.
//   - funct3 size encodings and the position of the unsigned bit
//   - FSM state enumeration
//   - size_bytes(): access size in bytes from the funct3 size field
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam int F3_UNSIGNED_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_BEAT1 = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_e;

  // 1, 2, 4 or 8 bytes
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational lane steering for lsu_ctrl.
//   Inputs : we, size, is_unsigned, offset (byte offset in the word),
//            wdata (LSB-justified store data), beat0/beat1 (captured read data)
//   Outputs: strb0/strb1 and wdata0/wdata1 for the first and second beat,
//            rdata_ext (merged, truncated and extended load result)
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                       we,
  input  logic [1:0]                 size,
  input  logic                       is_unsigned,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [XLEN-1:0]            wdata,
  input  logic [XLEN-1:0]            beat0,
  input  logic [XLEN-1:0]            beat1,
  output logic [XLEN/8-1:0]          strb0,
  output logic [XLEN/8-1:0]          strb1,
  output logic [XLEN-1:0]            wdata0,
  output logic [XLEN-1:0]            wdata1,
  output logic [XLEN-1:0]            rdata_ext
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(2 * XLEN);

  logic [3:0]        nbytes;
  logic [2*NB-1:0]   strb_base;
  logic [2*NB-1:0]   strb_wide;
  logic [2*XLEN-1:0] wdata_wide;
  logic [2*XLEN-1:0] rdata_wide;
  logic [LW-1:0]     sign_idx;
  logic              fill_bit;

  assign nbytes = size_bytes(size);

  // Shifting a double-width mask/data word by the offset yields both beats at
  // once: the low half is beat 0, whatever spills into the high half is beat 1.
  assign strb_base  = (2*NB)'((32'd1 << nbytes) - 32'd1);
  assign strb_wide  = strb_base << offset;
  assign wdata_wide = {{XLEN{1'b0}}, wdata} << {offset, 3'b000};

  assign strb0  = we ? strb_wide[NB-1:0]         : '0;
  assign strb1  = we ? strb_wide[2*NB-1:NB]      : '0;
  assign wdata0 = we ? wdata_wide[XLEN-1:0]      : '0;
  assign wdata1 = we ? wdata_wide[2*XLEN-1:XLEN] : '0;

  // Loads: undo the lane offset across both beats, then extend from the top
  // byte of the accessed size.
  assign rdata_wide = {beat1, beat0} >> {offset, 3'b000};
  assign sign_idx   = LW'({nbytes, 3'b000} - 7'd1);
  assign fill_bit   = is_unsigned ? 1'b0 : rdata_wide[sign_idx];

  for (genvar gi = 0; gi < NB; gi++) begin : g_ext
    assign rdata_ext[8*gi +: 8] = (4'(gi) < nbytes) ? rdata_wide[8*gi +: 8] : {8{fill_bit}};
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: handshaked load/store controller between execute and data memory.
//   Request : req_valid/req_ready, req_we, req_funct3, req_addr, req_wdata
//   Memory  : mem_valid/mem_ready, mem_addr, mem_wstrb, mem_wdata,
//             mem_rvalid, mem_rdata
//   Response: rsp_valid (one-cycle pulse), rsp_rdata, rsp_fault
//   Status  : busy (high whenever not idle)
// Word-crossing accesses are split into two beats, or faulted when
// SPLIT_MISALIGNED = 0. All mem_* and rsp_* outputs come straight from flops.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic              busy
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int EW = OW + 2;

  lsu_state_e state_reg, state_next;

  logic            we_reg,     we_next;
  logic [2:0]      funct3_reg, funct3_next;
  logic [XLEN-1:0] addr_reg,   addr_next;
  logic [XLEN-1:0] wdata_reg,  wdata_next;
  logic [XLEN-1:0] beat0_reg,  beat0_next;
  logic [XLEN-1:0] beat1_reg,  beat1_next;
  logic            cross_reg,  cross_next;
  logic            fault_reg,  fault_next;

  logic            mem_valid_reg, mem_valid_next;
  logic [XLEN-1:0] mem_addr_reg,  mem_addr_next;
  logic [NB-1:0]   mem_wstrb_reg, mem_wstrb_next;
  logic [XLEN-1:0] mem_wdata_reg, mem_wdata_next;
  logic            rsp_valid_reg, rsp_valid_next;
  logic [XLEN-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic            rsp_fault_reg, rsp_fault_next;

  logic [EW-1:0]   in_end;
  logic            in_cross;
  logic            in_illegal;
  logic            in_fault;
  logic [XLEN-1:0] aligned_next;

  logic [NB-1:0]   strb0, strb1;
  logic [XLEN-1:0] wdata0, wdata1, rdata_ext;

  // Classify the incoming request before it is registered
  always_comb begin
    in_end     = EW'(req_addr[OW-1:0]) + EW'(size_bytes(req_funct3[1:0]));
    in_cross   = in_end > EW'(NB);
    in_illegal = ((req_funct3[1:0] == SIZE_D) && (XLEN == 32))
               || (req_we && req_funct3[F3_UNSIGNED_BIT])
               || (!req_we && (req_funct3 == 3'b111))
               || (!req_we && (req_funct3 == 3'b110) && (XLEN == 32));
    in_fault   = in_illegal || (in_cross && (SPLIT_MISALIGNED == 0));
  end

  // Lane steering works on the next-cycle request view so that the registered
  // outputs already carry the right beat in the cycle after acceptance.
  lsu_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .we          (we_next),
    .size        (funct3_next[1:0]),
    .is_unsigned (funct3_next[F3_UNSIGNED_BIT]),
    .offset      (addr_next[OW-1:0]),
    .wdata       (wdata_next),
    .beat0       (beat0_next),
    .beat1       (beat1_next),
    .strb0       (strb0),
    .strb1       (strb1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .rdata_ext   (rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      we_reg        <= 1'b0;
      funct3_reg    <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      beat0_reg     <= '0;
      beat1_reg     <= '0;
      cross_reg     <= 1'b0;
      fault_reg     <= 1'b0;
      mem_valid_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wstrb_reg <= '0;
      mem_wdata_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_fault_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      we_reg        <= we_next;
      funct3_reg    <= funct3_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      beat0_reg     <= beat0_next;
      beat1_reg     <= beat1_next;
      cross_reg     <= cross_next;
      fault_reg     <= fault_next;
      mem_valid_reg <= mem_valid_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wstrb_reg <= mem_wstrb_next;
      mem_wdata_reg <= mem_wdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_fault_reg <= rsp_fault_next;
    end
  end

  // Next state and request capture
  always_comb begin
    state_next  = state_reg;
    we_next     = we_reg;
    funct3_next = funct3_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    beat0_next  = beat0_reg;
    beat1_next  = beat1_reg;
    cross_next  = cross_reg;
    fault_next  = fault_reg;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          we_next     = req_we;
          funct3_next = req_funct3;
          addr_next   = req_addr;
          wdata_next  = req_wdata;
          cross_next  = in_cross;
          fault_next  = in_fault;
          beat0_next  = '0;
          beat1_next  = '0;
          state_next  = in_fault ? ST_RESP : ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (mem_ready) begin
          if (!we_reg)        state_next = ST_WAIT0;
          else if (cross_reg) state_next = ST_BEAT1;
          else                state_next = ST_RESP;
        end
      end
      ST_WAIT0: begin
        if (mem_rvalid) begin
          beat0_next = mem_rdata;
          state_next = cross_reg ? ST_BEAT1 : ST_RESP;
        end
      end
      ST_BEAT1: begin
        if (mem_ready) begin
          state_next = we_reg ? ST_RESP : ST_WAIT1;
        end
      end
      ST_WAIT1: begin
        if (mem_rvalid) begin
          beat1_next = mem_rdata;
          state_next = ST_RESP;
        end
      end
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Registered outputs are a function of where the FSM is going
  always_comb begin
    aligned_next   = {addr_next[XLEN-1:OW], {OW{1'b0}}};
    mem_valid_next = (state_next == ST_BEAT0) || (state_next == ST_BEAT1);
    mem_addr_next  = '0;
    mem_wstrb_next = '0;
    mem_wdata_next = '0;
    if (state_next == ST_BEAT0) begin
      mem_addr_next  = aligned_next;
      mem_wstrb_next = strb0;
      mem_wdata_next = wdata0;
    end else if (state_next == ST_BEAT1) begin
      mem_addr_next  = aligned_next + XLEN'(NB);
      mem_wstrb_next = strb1;
      mem_wdata_next = wdata1;
    end
    rsp_valid_next = (state_next == ST_RESP);
    rsp_fault_next = rsp_valid_next && fault_next;
    rsp_rdata_next = (rsp_valid_next && !we_next && !fault_next) ? rdata_ext : '0;
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign mem_valid = mem_valid_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_fault = rsp_fault_reg;

endmodule
